multi_slot_controller: RTL and testbench
========================================

MULTI_SLOT_CONTROLLER -- requirements
Module: multi_slot_controller

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of pipeline trackers (legal 1..8); SW = max(1, clog2(NUM_SLOTS)).
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin run; sampled only in IDLE.
REQ-005 key_size  in  2  latched on start: 0->10 rounds, 1->12, 2->14, 3 treated as 10.
REQ-006 in_valid / in_ready  in / out  1 / 1  plaintext-key pair handshake; transfer when both are high.
REQ-007 in_last  in  1  qualifies the transferring pair as the last of the run.
REQ-008 init  out  1  one-cycle pulse that clears the datapath.
REQ-009 load_en / load_slot  out  1 / SW  write the accepted pair into the tracker load_slot.
REQ-010 comp_en / comp_slot / comp_round / comp_final  out  1 / SW / 4 / 1  perform round comp_round on the tracker comp_slot; comp_final high when comp_round equals NR.
REQ-011 out_valid / out_ready / out_slot  out / in / out  1 / 1 / SW  ciphertext retire handshake.
REQ-012 slot_busy  out  NUM_SLOTS  tracker occupancy vector.
REQ-013 done  out  1  one-cycle pulse at the end of the run.

Function
REQ-014 Top FSM states SHALL be IDLE, INIT, RUN, DONE: IDLE->INIT on start; INIT->RUN unconditionally; RUN->DONE when last_seen is set and every slot is FREE; DONE->IDLE unconditionally.
REQ-015 init SHALL be high only in INIT; done SHALL be high only in DONE; NR SHALL be latched in the IDLE->INIT cycle.
REQ-016 Each slot SHALL be FREE, ACTIVE(r) with r in 0..NR-1 completed rounds, or COMPLETE; slot_busy[i] = slot not FREE.
REQ-017 in_ready = (state RUN) and (last_seen is clear) and (at least one slot is FREE at the start of the cycle).
REQ-018 On transfer: the lowest-index FREE slot SHALL be allocated with load_en=1 and load_slot=that index in the same cycle; the slot becomes ACTIVE(0) and its id is pushed to the order FIFO (depth NUM_SLOTS); in_last sets last_seen.
REQ-019 Scheduler: each cycle in RUN, comp_en=1 if any slot is ACTIVE at the start of the cycle, choosing round-robin from the index after the last comp_slot; comp_round = r+1; the slot advances to ACTIVE(r+1), or to COMPLETE when r+1 = NR.
REQ-020 A slot loaded in cycle t SHALL first be eligible for compute in cycle t+1; load and compute of the same slot SHALL never share a cycle.
REQ-021 Retirement SHALL be in acceptance order: out_valid = FIFO non-empty and head slot COMPLETE; out_slot = head; on out_valid and out_ready the slot becomes FREE and the head pops.
REQ-022 A slot freed in cycle t SHALL not be allocated before cycle t+1; simultaneous retire and accept of different slots SHALL both proceed.
REQ-023 out_valid held while out_ready is low SHALL keep out_slot stable and stall nothing else.
REQ-024 start outside IDLE and in_valid outside RUN SHALL be ignored.
REQ-025 With NUM_SLOTS=1, the block SHALL serialise: one pair in flight, NR compute cycles, retire, then accept the next.

Reset
REQ-026 While rst=0: state IDLE, all slots FREE, FIFO empty, last_seen=0, round-robin pointer=0, NR=10, all outputs 0.
REQ-027 Reset asserted mid-run SHALL abandon all in-flight slots without further load/compute/out pulses; after release the block waits in IDLE for start.

Verification
REQ-028 start with key_size=0, one pair with in_last, out_ready=1 -> init at cycle 1, load slot 0, comp_round 1..10 on 10 consecutive cycles, out_valid slot 0, then done pulse.
REQ-029 NUM_SLOTS=4, 6 back-to-back pairs with key_size=2 -> in_ready low after 4 accepts; compute interleaves slots 0,1,2,3; retires in accept order; 14 rounds each.
REQ-030 out_ready held low for 20 cycles after the first COMPLETE -> out_slot stable; other slots finish; in_ready low once all slots are busy.
REQ-031 Retire slot 0 and offer a new pair in the same cycle with slots 1-3 busy -> pair not accepted that cycle; accepted into slot 0 the next cycle.
REQ-032 Reset pulled low mid-run with 3 slots ACTIVE -> all outputs 0 immediately; start after release runs cleanly from slot 0.
REQ-033 key_size=3 -> 10 rounds; start pulsed during RUN -> no second init.

Source files
------------

// File: rtl/multi_slot_controller.sv
// rtl/multi_slot_controller.sv - multi-slot round scheduler with in-order retirement
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i, key_size_i      begin a run (IDLE only); key size selects 10/12/14 rounds
//   in_valid_i/in_ready_o    pair handshake, in_last_i marks the final pair of the run
//   init_o, done_o           one-cycle pulses at run start / run end
//   load_en_o/load_slot_o    write accepted pair into a tracker slot
//   comp_en_o/comp_slot_o/comp_round_o/comp_final_o   one round on one slot per cycle
//   out_valid_o/out_ready_i/out_slot_o                retire handshake, acceptance order
//   slot_busy_o              per-slot occupancy
module multi_slot_controller #(
  parameter int NUM_SLOTS = 4,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           key_size_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_last_i,
  output logic                 init_o,
  output logic                 load_en_o,
  output logic [SW-1:0]        load_slot_o,
  output logic                 comp_en_o,
  output logic [SW-1:0]        comp_slot_o,
  output logic [3:0]           comp_round_o,
  output logic                 comp_final_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [SW-1:0]        out_slot_o,
  output logic [NUM_SLOTS-1:0] slot_busy_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           nr_q, nr_d;
  logic                 last_seen_q, last_seen_d;
  // A slot is FREE when !busy, ACTIVE(round) when busy && !cmpl, COMPLETE when cmpl.
  logic [NUM_SLOTS-1:0] busy_q, busy_d;
  logic [NUM_SLOTS-1:0] cmpl_q, cmpl_d;
  logic [3:0]           round_q [NUM_SLOTS];
  logic [3:0]           round_d [NUM_SLOTS];
  logic [SW-1:0]        rr_q, rr_d;          // first index searched by the scheduler
  logic [SW-1:0]        fifo_q [NUM_SLOTS];
  logic [SW-1:0]        fifo_d [NUM_SLOTS];
  logic [SW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [SW:0]          cnt_q, cnt_d;

  logic [NUM_SLOTS-1:0] active;
  logic                 any_free;
  logic [SW-1:0]        alloc_slot;
  logic                 rr_found;
  logic [SW-1:0]        rr_sel;
  logic [SW-1:0]        head_slot;
  logic                 head_done;
  logic [3:0]           rnext;

  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
    return (int'(p) == NUM_SLOTS - 1) ? '0 : p + 1'b1;
  endfunction

  assign active      = busy_q & ~cmpl_q;
  assign any_free    = |(~busy_q);
  assign head_slot   = fifo_q[rd_q];
  assign head_done   = (cnt_q != '0) && cmpl_q[head_slot];
  assign slot_busy_o = busy_q;
  assign in_ready_o  = (state_q == S_RUN) && !last_seen_q && any_free;

  // Lowest-index free slot, taken from registered state so a slot freed this
  // cycle cannot be reallocated until the next one.
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_slot = SW'(i);
    end
  end

  // Round-robin pick among ACTIVE slots starting at rr_q.
  always_comb begin : rr_pick
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
      if (!rr_found && active[idx]) begin
        rr_found = 1'b1;
        rr_sel   = SW'(idx);
      end
    end
  end

  assign rnext = round_q[rr_sel] + 4'd1;

  always_comb begin
    state_d     = state_q;
    nr_d        = nr_q;
    last_seen_d = last_seen_q;
    busy_d      = busy_q;
    cmpl_d      = cmpl_q;
    round_d     = round_q;
    rr_d        = rr_q;
    fifo_d      = fifo_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;

    init_o       = 1'b0;
    done_o       = 1'b0;
    load_en_o    = 1'b0;
    load_slot_o  = '0;
    comp_en_o    = 1'b0;
    comp_slot_o  = '0;
    comp_round_o = '0;
    comp_final_o = 1'b0;
    out_valid_o  = 1'b0;
    out_slot_o   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_INIT;
          unique case (key_size_i)
            2'd1:    nr_d = 4'd12;
            2'd2:    nr_d = 4'd14;
            default: nr_d = 4'd10;
          endcase
        end
      end

      S_INIT: begin
        init_o      = 1'b1;
        busy_d      = '0;
        cmpl_d      = '0;
        last_seen_d = 1'b0;
        rr_d        = '0;
        wr_d        = '0;
        rd_d        = '0;
        cnt_d       = '0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        // Accept, compute and retire act on slots in distinct states, so their
        // updates never collide on the same slot within one cycle.
        if (in_valid_i && in_ready_o) begin
          load_en_o           = 1'b1;
          load_slot_o         = alloc_slot;
          busy_d[alloc_slot]  = 1'b1;
          cmpl_d[alloc_slot]  = 1'b0;
          round_d[alloc_slot] = 4'd0;
          fifo_d[wr_q]        = alloc_slot;
          wr_d                = wrap_inc(wr_q);
          if (in_last_i) last_seen_d = 1'b1;
        end

        if (rr_found) begin
          comp_en_o       = 1'b1;
          comp_slot_o     = rr_sel;
          comp_round_o    = rnext;
          comp_final_o    = (rnext == nr_q);
          round_d[rr_sel] = rnext;
          if (rnext == nr_q) cmpl_d[rr_sel] = 1'b1;
          rr_d = wrap_inc(rr_sel);
        end

        if (head_done) begin
          out_valid_o = 1'b1;
          out_slot_o  = head_slot;
          if (out_ready_i) begin
            busy_d[head_slot] = 1'b0;
            cmpl_d[head_slot] = 1'b0;
            rd_d              = wrap_inc(rd_q);
          end
        end

        unique case ({load_en_o, out_valid_o && out_ready_i})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase

        if (last_seen_q && (busy_q == '0)) state_d = S_DONE;
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      nr_q        <= 4'd10;
      last_seen_q <= 1'b0;
      busy_q      <= '0;
      cmpl_q      <= '0;
      rr_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        round_q[i] <= '0;
        fifo_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      nr_q        <= nr_d;
      last_seen_q <= last_seen_d;
      busy_q      <= busy_d;
      cmpl_q      <= cmpl_d;
      rr_q        <= rr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      round_q     <= round_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule

// File: tb/tb_multi_slot_controller.sv
// tb/tb_multi_slot_controller.sv - directed bench for multi_slot_controller
module tb_multi_slot_controller;

  logic       clk, rst_n;
  logic       start, in_valid, in_ready, in_last;
  logic [1:0] key_size;
  logic       init, load_en, comp_en, comp_final, out_valid, out_ready, done;
  logic [1:0] load_slot, comp_slot, out_slot;
  logic [3:0] comp_round;
  logic [3:0] slot_busy;
  logic [20:0] all_outs;

  int n_assert = 0;
  int n_fail   = 0;

  multi_slot_controller #(.NUM_SLOTS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_size_i(key_size),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .init_o(init), .load_en_o(load_en), .load_slot_o(load_slot),
    .comp_en_o(comp_en), .comp_slot_o(comp_slot), .comp_round_o(comp_round),
    .comp_final_o(comp_final), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_slot_o(out_slot), .slot_busy_o(slot_busy), .done_o(done)
  );

  assign all_outs = {init, load_en, load_slot, comp_en, comp_slot, comp_round, comp_final,
                     out_valid, out_slot, slot_busy, done, in_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comp(input string tag, input logic en, input int slot, input int rnd, input int nr);
    logic [7:0] e;
    e = en ? {1'b1, 2'(slot), 4'(rnd), (rnd == nr)} : 8'h0;
    chk(tag, {24'h0, comp_en, comp_slot, comp_round, comp_final}, {24'h0, e});
  endtask

  task automatic chk_in(input string tag, input logic rdy, input logic ld, input int slot);
    chk(tag, {28'h0, in_ready, load_en, load_slot}, {28'h0, rdy, ld, ld ? 2'(slot) : 2'd0});
  endtask

  task automatic chk_out(input string tag, input logic v, input int slot);
    chk(tag, {29'h0, out_valid, out_slot}, {29'h0, v, v ? 2'(slot) : 2'd0});
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic drive(input logic st, input logic v, input logic last, input logic ordy);
    @(negedge clk);
    start = st; in_valid = v; in_last = last; out_ready = ordy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; key_size = 2'd0;
    #1;
    chk("reset_outs", {11'h0, all_outs}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- single pair, 10 rounds, in_valid ignored in IDLE ----
    key_size = 2'd0;
    drive(1, 1, 0, 1);
    chk_in("a_idle_in", 0, 0, 0);
    chk("a_idle_init", {31'h0, init}, 32'h0);
    drive(0, 0, 0, 1);
    chk("a_init", {31'h0, init}, 32'h1);
    chk_in("a_init_in", 0, 0, 0);
    drive(0, 1, 1, 1);
    chk_in("a_load", 1, 1, 0);
    chk_comp("a_nocomp", 0, 0, 0, 10);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 1);
      chk_comp("a_comp", 1, 0, k, 10);
      chk("a_busy", {28'h0, slot_busy}, 32'h1);
      chk_in("a_in_closed", 0, 0, 0);
    end
    drive(0, 0, 0, 1);
    chk_out("a_retire", 1, 0);
    chk_comp("a_comp_idle", 0, 0, 0, 10);
    drive(0, 0, 0, 1);
    chk_out("a_after", 0, 0);
    chk("a_done_early", {31'h0, done}, 32'h0);
    drive(0, 0, 0, 1);
    chk("a_done", {31'h0, done}, 32'h1);
    drive(0, 0, 0, 1);
    chk("a_idle_outs", {11'h0, all_outs}, 32'h0);

    // ---- six back-to-back pairs, 14 rounds ----
    key_size = 2'd2;
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("b_init", {31'h0, init}, 32'h1);
    for (int n = 0; n <= 53; n++) begin
      drive(0, 1, 0, 1);
      chk_in("b_in", n <= 3, n <= 3, n);
      chk_comp("b_comp", n >= 1, (n - 1) % 4, (n - 1) / 4 + 1, 14);
      chk_out("b_no_out", 0, 0);
      if (n >= 4) chk("b_busy", {28'h0, slot_busy}, 32'hF);
    end
    drive(0, 1, 0, 1);          // r54
    chk_in("b54_in", 0, 0, 0);
    chk_out("b54_out", 1, 0);
    chk_comp("b54_comp", 1, 1, 14, 14);
    drive(0, 1, 0, 1);          // r55
    chk_in("b55_in", 1, 1, 0);
    chk_out("b55_out", 1, 1);
    chk_comp("b55_comp", 1, 2, 14, 14);
    drive(0, 1, 1, 1);          // r56
    chk_in("b56_in", 1, 1, 1);
    chk_out("b56_out", 1, 2);
    chk_comp("b56_comp", 1, 3, 14, 14);
    drive(0, 0, 0, 1);          // r57
    chk_in("b57_in", 0, 0, 0);
    chk_out("b57_out", 1, 3);
    chk_comp("b57_comp", 1, 0, 1, 14);
    drive(0, 0, 0, 1);          // r58
    chk_out("b58_out", 0, 0);
    chk_comp("b58_comp", 1, 1, 1, 14);
    for (int n = 59; n <= 83; n++) begin
      drive(0, 0, 0, 1);
      if (n % 2 == 1) chk_comp("b_alt", 1, 0, (n - 57) / 2 + 1, 14);
      else            chk_comp("b_alt", 1, 1, (n - 58) / 2 + 1, 14);
      chk_out("b_alt_out", 0, 0);
    end
    drive(0, 0, 0, 1);          // r84
    chk_out("b84_out", 1, 0);
    chk_comp("b84_comp", 1, 1, 14, 14);
    drive(0, 0, 0, 1);          // r85
    chk_out("b85_out", 1, 1);
    chk_comp("b85_comp", 0, 0, 0, 14);
    drive(0, 0, 0, 1);          // r86
    chk("b86_done", {27'h0, done, slot_busy}, 32'h0);
    drive(0, 0, 0, 1);          // r87
    chk("b87_done", {31'h0, done}, 32'h1);

    // ---- retire back-pressure, then retire/accept in the same cycle ----
    key_size = 2'd0;
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("c_init", {31'h0, init}, 32'h1);
    for (int n = 0; n <= 57; n++) begin
      drive(0, 1, n >= 4, 0);
      chk_in("c_in", n <= 3, n <= 3, n);
      chk_comp("c_comp", (n >= 1) && (n <= 40), (n - 1) % 4, (n - 1) / 4 + 1, 10);
      chk_out("c_hold", n >= 38, 0);
    end
    drive(0, 1, 1, 1);          // r58: slot 0 retires, no free slot at cycle start
    chk_out("c58_out", 1, 0);
    chk_in("c58_in", 0, 0, 0);
    drive(0, 1, 1, 1);          // r59: slot 0 reused
    chk_out("c59_out", 1, 1);
    chk_in("c59_in", 1, 1, 0);
    drive(0, 0, 0, 1);          // r60
    chk_out("c60_out", 1, 2);
    chk_in("c60_in", 0, 0, 0);
    chk_comp("c60_comp", 1, 0, 1, 10);
    drive(0, 0, 0, 1);          // r61
    chk_out("c61_out", 1, 3);
    chk_comp("c61_comp", 1, 0, 2, 10);
    for (int k = 3; k <= 10; k++) begin
      drive(0, 0, 0, 1);
      chk_comp("c_tail", 1, 0, k, 10);
      chk_out("c_tail_out", 0, 0);
    end
    drive(0, 0, 0, 1);          // r70
    chk_out("c70_out", 1, 0);
    drive(0, 0, 0, 1);          // r71
    chk("c71_done", {31'h0, done}, 32'h0);
    drive(0, 0, 0, 1);          // r72
    chk("c72_done", {31'h0, done}, 32'h1);

    // ---- reset mid-run with three slots active ----
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 0, 0, 1);
    chk_comp("d_pre_comp", 1, 2, 1, 10);
    chk("d_pre_busy", {28'h0, slot_busy}, 32'h7);
    rst_n = 1'b0;
    #1;
    chk("d_rst_now", {11'h0, all_outs}, 32'h0);
    drive(0, 1, 0, 1);
    chk("d_rst_hold", {11'h0, all_outs}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 1);
    chk("d_post_idle", {11'h0, all_outs}, 32'h0);

    // ---- key_size 3 -> 10 rounds, start ignored during RUN ----
    key_size = 2'd3;
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("e_init", {31'h0, init}, 32'h1);
    drive(0, 1, 1, 1);
    chk_in("e_load", 1, 1, 0);
    drive(1, 0, 0, 1);
    chk_comp("e_comp1", 1, 0, 1, 10);
    for (int k = 2; k <= 10; k++) begin
      drive(0, 0, 0, 1);
      chk("e_no_init", {31'h0, init}, 32'h0);
      chk_comp("e_comp", 1, 0, k, 10);
    end
    drive(0, 0, 0, 1);
    chk_out("e_retire", 1, 0);
    drive(0, 0, 0, 1);
    chk("e_done_early", {31'h0, done}, 32'h0);
    drive(0, 0, 0, 1);
    chk("e_done", {31'h0, done}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
